instr_fetch_decode: RTL

- Upstream stage of the processor register-file block.
- Keeps the PC and fetches 32-bit instructions from the synchronous instruction ROM.
- Decodes each instruction into `rs1`, `rs2`, `rd`, `op_code`, `funct3` and a sign-extended immediate.
- Hands the decoded bundle to the register-file/execute side over a valid/ready handshake, and accepts branch redirects from downstream.

---
 rtl/instr_fetch_decode_pkg.sv | 57 +++++
 rtl/instr_fetch_decode_imm_gen.sv | 29 ++
 rtl/instr_fetch_decode.sv | 133 +++++++++++++
 3 files changed

// File: rtl/instr_fetch_decode_pkg.sv
// Purpose: shared opcodes, FSM state encoding and immediate formats for instr_fetch_decode.
// Latency: none (declarations and a combinational helper only).
// Backpressure: not applicable.
// Option: ILLEGAL_HALT_EN adds the S_HALT state.
package instr_fetch_decode_pkg;

    localparam logic [6:0] OP_IMM = 7'b0010011;
    localparam logic [6:0] LOAD   = 7'b0000011;
    localparam logic [6:0] JALR   = 7'b1100111;
    localparam logic [6:0] STORE  = 7'b0100011;
    localparam logic [6:0] BRANCH = 7'b1100011;
    localparam logic [6:0] LUI    = 7'b0110111;
    localparam logic [6:0] AUIPC  = 7'b0010111;
    localparam logic [6:0] JAL    = 7'b1101111;
    localparam logic [6:0] OP     = 7'b0110011;

`ifdef ILLEGAL_HALT_EN
    typedef enum logic [1:0] {
        S_FETCH  = 2'd0,
        S_DECODE = 2'd1,
        S_ISSUE  = 2'd2,
        S_HALT   = 2'd3
    } state_t;
`else
    typedef enum logic [1:0] {
        S_FETCH  = 2'd0,
        S_DECODE = 2'd1,
        S_ISSUE  = 2'd2
    } state_t;
`endif

    typedef enum logic [2:0] {
        FMT_NONE = 3'd0,
        FMT_I    = 3'd1,
        FMT_S    = 3'd2,
        FMT_B    = 3'd3,
        FMT_U    = 3'd4,
        FMT_J    = 3'd5,
        FMT_R    = 3'd6
    } imm_fmt_t;

    // Map an opcode to its immediate format; FMT_NONE marks an unrecognised opcode.
    function automatic imm_fmt_t fmt_of(input logic [6:0] op);
        imm_fmt_t f;
        case (op)
            OP_IMM, LOAD, JALR: f = FMT_I;
            STORE:              f = FMT_S;
            BRANCH:             f = FMT_B;
            LUI, AUIPC:         f = FMT_U;
            JAL:                f = FMT_J;
            OP:                 f = FMT_R;
            default:            f = FMT_NONE;
        endcase
        return f;
    endfunction

endpackage

// File: rtl/instr_fetch_decode_imm_gen.sv
// Purpose: builds the sign-extended immediate for each instruction format.
// Latency: purely combinational.
// Backpressure: none; follows its inputs.
module imm_gen
    import instr_fetch_decode_pkg::*;
#(
    parameter int WORDSIZE = 64
) (
    input  logic [31:7]         inst,
    input  imm_fmt_t            fmt,
    output logic [WORDSIZE-1:0] imm
);

    // Reassemble the scattered immediate bits and sign-extend from inst[31].
    always_comb begin
        imm = '0;
        case (fmt)
            FMT_I: imm = {{(WORDSIZE-12){inst[31]}}, inst[31:20]};
            FMT_S: imm = {{(WORDSIZE-12){inst[31]}}, inst[31:25], inst[11:7]};
            FMT_B: imm = {{(WORDSIZE-13){inst[31]}}, inst[31], inst[7], inst[30:25],
                          inst[11:8], 1'b0};
            FMT_U: imm = {{(WORDSIZE-32){inst[31]}}, inst[31:12], 12'b0};
            FMT_J: imm = {{(WORDSIZE-21){inst[31]}}, inst[31], inst[19:12], inst[20],
                          inst[30:21], 1'b0};
            default: imm = '0;
        endcase
    end

endmodule

// File: rtl/instr_fetch_decode.sv
// Purpose: PC keeper, instruction ROM fetch and decode into a registered bundle.
// Latency: first bundle 2 edges after reset release; at most one bundle per 2 cycles.
// Backpressure: bundle and PC held while out_ready=0; branch_taken redirects in any state.
// Option: ILLEGAL_HALT_EN parks the fetcher in S_HALT after an illegal bundle is accepted.
module instr_fetch_decode
    import instr_fetch_decode_pkg::*;
#(
    parameter int                  WORDSIZE = 64,
    parameter int                  SIZE     = 32,
    parameter logic [WORDSIZE-1:0] PC_RESET = '0
) (
    input  logic                clk,
    input  logic                rst_n,
    output logic [WORDSIZE-1:0] rom_addr,
    input  logic [SIZE-1:0]     rom_data,
    input  logic                branch_taken,
    input  logic [WORDSIZE-1:0] branch_target,
    output logic                out_valid,
    input  logic                out_ready,
    output logic [4:0]          rs1,
    output logic [4:0]          rs2,
    output logic [4:0]          rd,
    output logic [6:0]          op_code,
    output logic [2:0]          funct3,
    output logic [WORDSIZE-1:0] imm,
    output logic [WORDSIZE-1:0] pc_out,
    output logic                illegal
);

    state_t              state;
    state_t              state_nxt;
    logic [WORDSIZE-1:0] pc;
    logic [WORDSIZE-1:0] redirect_pc;
    logic [31:0]         inst;
    imm_fmt_t            fmt;
    logic [4:0]          d_rs1;
    logic [4:0]          d_rs2;
    logic [4:0]          d_rd;
    logic                d_illegal;
    logic [WORDSIZE-1:0] d_imm;

    assign rom_addr    = pc;
    assign inst        = rom_data[31:0];
    // Redirect targets are forced word aligned.
    assign redirect_pc = branch_target & ~WORDSIZE'(3);

    imm_gen #(.WORDSIZE(WORDSIZE)) u_imm_gen (
        .inst (inst[31:7]),
        .fmt  (fmt),
        .imm  (d_imm)
    );

    // Field extraction; unused register fields are zeroed per format, raw for unknown opcodes.
    always_comb begin
        fmt       = fmt_of(inst[6:0]);
        d_rs1     = inst[19:15];
        d_rs2     = inst[24:20];
        d_rd      = inst[11:7];
        d_illegal = 1'b0;
        case (fmt)
            FMT_I:        d_rs2 = '0;
            FMT_S, FMT_B: d_rd  = '0;
            FMT_U, FMT_J: begin
                d_rs1 = '0;
                d_rs2 = '0;
            end
            FMT_R:        d_illegal = 1'b0;
            default:      d_illegal = 1'b1;
        endcase
    end

    // State register.
    always_ff @(posedge clk) begin
        if (!rst_n) state <= S_FETCH;
        else        state <= state_nxt;
    end

    // Next-state logic; a redirect wins over everything, including an accepted bundle.
    always_comb begin
        state_nxt = state;
        case (state)
            S_FETCH:  state_nxt = S_DECODE;
            S_DECODE: state_nxt = S_ISSUE;
            S_ISSUE: begin
                if (out_valid && out_ready) begin
`ifdef ILLEGAL_HALT_EN
                    state_nxt = illegal ? S_HALT : S_DECODE;
`else
                    state_nxt = S_DECODE;
`endif
                end
            end
`ifdef ILLEGAL_HALT_EN
            S_HALT:   state_nxt = S_HALT;
`endif
            default:  state_nxt = S_FETCH;
        endcase
        if (branch_taken) state_nxt = S_FETCH;
    end

    // PC and output bundle; fields only change on decode, so a redirect drops just out_valid.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            pc        <= PC_RESET;
            out_valid <= 1'b0;
            rs1       <= '0;
            rs2       <= '0;
            rd        <= '0;
            op_code   <= '0;
            funct3    <= '0;
            imm       <= '0;
            pc_out    <= '0;
            illegal   <= 1'b0;
        end else if (branch_taken) begin
            pc        <= redirect_pc;
            out_valid <= 1'b0;
        end else if (state == S_DECODE) begin
            rs1       <= d_rs1;
            rs2       <= d_rs2;
            rd        <= d_rd;
            op_code   <= inst[6:0];
            funct3    <= inst[14:12];
            imm       <= d_imm;
            illegal   <= d_illegal;
            pc_out    <= pc;
            pc        <= pc + WORDSIZE'(4);
            out_valid <= 1'b1;
        end else if (state == S_ISSUE && out_ready) begin
            out_valid <= 1'b0;
        end
    end

endmodule
